// File: rtl/cond_logic.sv
// cond_logic: conditional-execution stage behind the main decoder.
// Holds the NZCV flag register and checks the instruction's condition field
// against it. It masks the branch, register-write and memory-write strobes of
// instructions whose condition fails. It also keeps saturating counters of
// executed and squashed instructions.
//
// Optional feature macro: COND_NV_TRAP_EN
//   defined   : Cond=4'b1111 always fails; nv_trap pulses the cycle after it.
//   undefined : Cond=4'b1111 behaves as AL and there is no nv_trap port.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   instr_valid         current cycle carries a real instruction
//   Cond                condition field (Instr[31:28])
//   ALUFlags            {N,Z,C,V} from the ALU
//   FlagW               [1] update N,Z  [0] update C,V
//   Branch/RegW/MemW    decoder strobes to be gated
//   NoWrite             compare-type op, suppresses RegWrite
//   cnt_clr             synchronous clear of both counters
//   PCSrc/RegWrite/MemWrite  gated strobes (combinational)
//   CondEx              condition passed (combinational)
//   Flags               registered {N,Z,C,V}
//   exec_cnt/skip_cnt   saturating executed / squashed counts
//   nv_trap             (COND_NV_TRAP_EN only) one-cycle pulse after Cond=1111
module cond_logic #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             Branch,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             cnt_clr,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] exec_cnt,
`ifdef COND_NV_TRAP_EN
  output logic [CNT_W-1:0] skip_cnt,
  output logic             nv_trap
`else
  output logic [CNT_W-1:0] skip_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic n, z, c, v;
  logic cond_pass;

  assign {n, z, c, v} = Flags;

  // Condition evaluation against the registered flags
  always_comb begin
    cond_pass = 1'b0;
    case (Cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
`ifdef COND_NV_TRAP_EN
      4'b1111: cond_pass = 1'b0;
`else
      4'b1111: cond_pass = 1'b1;
`endif
      default: cond_pass = 1'b0;
    endcase
  end

  // Strobe gating
  always_comb begin
    CondEx   = instr_valid & cond_pass;
    PCSrc    = Branch & CondEx;
    RegWrite = RegW & CondEx & ~NoWrite;
    MemWrite = MemW & CondEx;
  end

  // Flag register: N,Z and C,V update independently, only for executed instructions
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else begin
      if (CondEx && FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (CondEx && FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Saturating executed/squashed counters; clear wins over counting
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_cnt <= '0;
      skip_cnt <= '0;
    end else if (cnt_clr) begin
      exec_cnt <= '0;
      skip_cnt <= '0;
    end else if (instr_valid) begin
      if (CondEx) begin
        if (exec_cnt != CNT_MAX) exec_cnt <= exec_cnt + CNT_W'(1);
      end else begin
        if (skip_cnt != CNT_MAX) skip_cnt <= skip_cnt + CNT_W'(1);
      end
    end
  end

`ifdef COND_NV_TRAP_EN
  // One-cycle pulse after a valid never-execute encoding
  always_ff @(posedge clk) begin
    if (reset) nv_trap <= 1'b0;
    else       nv_trap <= instr_valid & (Cond == 4'b1111);
  end
`endif

endmodule

// File: tb/tb_cond_logic.sv
module tb_cond_logic;
  localparam int unsigned CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset, instr_valid, Branch, RegW, MemW, NoWrite, cnt_clr;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;
  logic [CNT_W-1:0] exec_cnt, skip_cnt;
`ifdef COND_NV_TRAP_EN
  logic nv_trap;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic [3:0] m_flags;
  int m_exec, m_skip;
  logic m_trap;

  always #5 clk = ~clk;

  cond_logic #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .Branch(Branch), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .cnt_clr(cnt_clr), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
    .exec_cnt(exec_cnt),
`ifdef COND_NV_TRAP_EN
    .skip_cnt(skip_cnt), .nv_trap(nv_trap)
`else
    .skip_cnt(skip_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Conditions come in complementary pairs: Cond[0] inverts the base predicate
  function automatic logic m_cond(input logic [3:0] cnd, input logic [3:0] f);
    logic fn, fz, fc, fv, base;
    {fn, fz, fc, fv} = f;
    if (cnd[3:1] == 3'b111) begin
`ifdef COND_NV_TRAP_EN
      return !cnd[0];
`else
      return 1'b1;
`endif
    end
    case (cnd[3:1])
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fn;
      3'd3: base = fv;
      3'd4: base = fc && !fz;
      3'd5: base = (fn == fv);
      default: base = !fz && (fn == fv);
    endcase
    return base ^ cnd[0];
  endfunction

  function automatic logic m_ex();
    return instr_valid && m_cond(Cond, m_flags);
  endfunction

  // Model update on each rising edge
  always @(posedge clk) begin
    logic ex;
    ex = m_ex();
    if (reset) begin
      m_flags = 4'b0000; m_exec = 0; m_skip = 0; m_trap = 1'b0;
    end else begin
      m_trap = instr_valid && (Cond == 4'b1111);
      if (ex && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
      if (ex && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
      if (cnt_clr) begin
        m_exec = 0; m_skip = 0;
      end else if (instr_valid) begin
        if (ex) m_exec = (m_exec < CMAX) ? m_exec + 1 : CMAX;
        else    m_skip = (m_skip < CMAX) ? m_skip + 1 : CMAX;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic ex;
      ex = m_ex();
      chk("cycle_condex", 32'(CondEx), 32'(ex));
      chk("cycle_pcsrc", 32'(PCSrc), 32'(Branch && ex));
      chk("cycle_regwrite", 32'(RegWrite), 32'(RegW && ex && !NoWrite));
      chk("cycle_memwrite", 32'(MemWrite), 32'(MemW && ex));
      chk("cycle_flags", 32'(Flags), 32'(m_flags));
      chk("cycle_exec_cnt", 32'(exec_cnt), 32'(m_exec));
      chk("cycle_skip_cnt", 32'(skip_cnt), 32'(m_skip));
`ifdef COND_NV_TRAP_EN
      chk("cycle_nv_trap", 32'(nv_trap), 32'(m_trap));
`endif
    end
  end

  task automatic drive(input logic iv, input logic [3:0] cnd, input logic [3:0] af,
                       input logic [1:0] fw, input logic br, input logic rw,
                       input logic mw, input logic nw, input logic clr);
    instr_valid = iv; Cond = cnd; ALUFlags = af; FlagW = fw;
    Branch = br; RegW = rw; MemW = mw; NoWrite = nw; cnt_clr = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("reset_flags", 32'(Flags), 32'h0);
    chk("reset_exec", 32'(exec_cnt), 32'h0);
    chk("reset_skip", 32'(skip_cnt), 32'h0);
    chk("reset_pcsrc", 32'(PCSrc), 32'h0);

    // AL with full flag write
    drive(1, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 0, 0);
    chk("al_regwrite", 32'(RegWrite), 32'h1);
    tick();
    chk("al_flags", 32'(Flags), 32'h4);
    chk("al_exec", 32'(exec_cnt), 32'h1);

    // NE with Z set fails; flags must not move
    drive(1, 4'h1, 4'b1111, 2'b11, 1, 0, 1, 0, 0);
    chk("ne_condex", 32'(CondEx), 32'h0);
    chk("ne_memwrite", 32'(MemWrite), 32'h0);
    chk("ne_pcsrc", 32'(PCSrc), 32'h0);
    tick();
    chk("ne_flags", 32'(Flags), 32'h4);
    chk("ne_skip", 32'(skip_cnt), 32'h1);

    // Partial update: only C,V
    drive(1, 4'hE, 4'b1001, 2'b11, 0, 0, 0, 0, 0); tick();
    drive(1, 4'hE, 4'b0110, 2'b01, 0, 0, 0, 0, 0); tick();
    chk("cv_flags", 32'(Flags), 32'hA);
    drive(1, 4'hA, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    chk("ge_condex", 32'(CondEx), 32'h0);
    drive(1, 4'hB, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    chk("lt_condex", 32'(CondEx), 32'h1);
    tick();

    // Compare-type op: no register write, flags still written
    drive(1, 4'hE, 4'b0011, 2'b11, 0, 1, 0, 1, 0);
    chk("nowrite_regwrite", 32'(RegWrite), 32'h0);
    tick();
    chk("nowrite_flags", 32'(Flags), 32'h3);
    chk("nowrite_exec", 32'(exec_cnt), 32'h5);

    // Failing condition with FlagW=11
    drive(1, 4'h0, 4'b1111, 2'b11, 0, 0, 0, 0, 0); tick();
    chk("fail_fw_flags", 32'(Flags), 32'h3);
    chk("fail_fw_skip", 32'(skip_cnt), 32'h2);

    // Invalid slot: nothing happens
    drive(0, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0, 0);
    chk("invalid_condex", 32'(CondEx), 32'h0);
    chk("invalid_regwrite", 32'(RegWrite), 32'h0);
    tick();
    chk("invalid_flags", 32'(Flags), 32'h3);
    chk("invalid_exec", 32'(exec_cnt), 32'h5);

    // Saturation
    for (int i = 0; i < 20; i++) begin
      drive(1, 4'hE, 4'b0000, 2'b00, 0, 1, 0, 0, 0); tick();
    end
    chk("sat_exec", 32'(exec_cnt), 32'hF);

    // Clear beats increment
    drive(1, 4'hE, 4'b0000, 2'b00, 0, 1, 0, 0, 1); tick();
    chk("clr_exec", 32'(exec_cnt), 32'h0);
    chk("clr_skip", 32'(skip_cnt), 32'h0);
    chk("clr_flags", 32'(Flags), 32'h3);

    // Sweep every condition against every flag value
    for (int f = 0; f < 16; f++) begin
      drive(1, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0, 0); tick();
      for (int cnd = 0; cnd < 15; cnd++) begin
        drive(1, 4'(cnd), 4'(15 - f), 2'(cnd), 1, 1, 1, 0, 0); tick();
        drive(1, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0, 0); tick();
      end
    end

    // Never-execute encoding
    drive(1, 4'hE, 4'b0000, 2'b11, 0, 0, 0, 0, 1); tick();
    drive(1, 4'hF, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
`ifdef COND_NV_TRAP_EN
    chk("nv_regwrite", 32'(RegWrite), 32'h0);
    tick();
    chk("nv_trap_set", 32'(nv_trap), 32'h1);
    chk("nv_skip", 32'(skip_cnt), 32'h1);
    drive(0, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 0); tick();
    chk("nv_trap_clear", 32'(nv_trap), 32'h0);
`else
    chk("nv_regwrite", 32'(RegWrite), 32'h1);
    tick();
    chk("nv_exec", 32'(exec_cnt), 32'h1);
`endif

    // Reset mid-stream wins over a flag write
    drive(1, 4'hE, 4'b1111, 2'b11, 0, 1, 0, 0, 0); tick();
    chk("pre_rst_flags", 32'(Flags), 32'hF);
    reset = 1'b1;
    drive(1, 4'hE, 4'b1111, 2'b11, 0, 1, 0, 0, 0); tick();
    chk("rst_flags", 32'(Flags), 32'h0);
    chk("rst_exec", 32'(exec_cnt), 32'h0);
    reset = 1'b0;
    drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0); tick(); tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
